// File: rtl/ahb_sub_regbank_if.sv
// ahb_sub_regbank_if: AHB-Lite bus bundle between a manager/interconnect and the register bank.
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HWSTRB, HREADY : manager/interconnect -> subordinate
//   HRDATA, HREADYOUT, HRESP                                            : subordinate -> manager/interconnect
interface ahb_sub_regbank_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W/8-1:0] HWSTRB;
    logic              HREADY;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADYOUT;
    logic              HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HWSTRB, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HWSTRB, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_sub_regbank.sv
// ahb_sub_regbank: AHB-Lite subordinate register bank with RW/RO registers, wait states and two-cycle error response.
//   HCLK     : clock, rising edge
//   HRESET   : asynchronous active-high reset
//   bus      : ahb_sub_regbank_if.slave (AHB-Lite address/data/response signals)
//   status_i : NUM_REGS*DATA_W read values of read-only registers
//   reg_q    : NUM_REGS*DATA_W current contents of all registers
// Optional macro AHB_REGBANK_WSTRB_EN: honour HWSTRB per byte; otherwise whole-register writes.
module ahb_sub_regbank #(
    parameter int                   ADDR_W      = 12,
    parameter int                   DATA_W      = 32,
    parameter int                   NUM_REGS    = 16,
    parameter int                   WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
    parameter logic [DATA_W-1:0]    RESET_VAL   = '0
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    ahb_sub_regbank_if.slave             bus,
    input  logic [NUM_REGS*DATA_W-1:0]   status_i,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = ADDR_W - LB;
    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR1 = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              dp_q, dp_d;
    logic              wr_q, wr_d;
    logic [RW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] stat [NUM_REGS];
    logic [IW-1:0]     idx_a;
    logic [LB-1:0]     amask;
    logic              acc, err, done, hready;
    logic [DATA_W-1:0] wval, rval;
    logic              unused;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign stat[i] = status_i[i*DATA_W +: DATA_W];
        assign reg_q[i*DATA_W +: DATA_W] = RO_MASK[i] ? stat[i] : regs_q[i];
    end

    assign idx_a = bus.HADDR[ADDR_W-1:LB];
    assign amask = LB'((32'd1 << bus.HSIZE) - 32'd1);
    assign acc   = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    // Out-of-range index already forces an error, so the RO lookup may alias harmlessly.
    assign err   = (32'(idx_a) >= NUM_REGS)
                 | (bus.HWRITE & RO_MASK[idx_a[RW-1:0]])
                 | (32'(bus.HSIZE) > LB)
                 | (|(bus.HADDR[LB-1:0] & amask));

    // A pending data phase completes when no wait cycles remain.
    assign done   = dp_q & ((state_q == S_IDLE) | ((state_q == S_WAIT) & (cnt_q == 3'd0)));
    assign hready = !((state_q == S_ERR1) || ((state_q == S_WAIT) && (cnt_q != 3'd0)));
    assign rval   = RO_MASK[idx_q] ? stat[idx_q] : regs_q[idx_q];

    assign bus.HREADYOUT = hready;
    assign bus.HRESP     = (state_q == S_ERR1) | (state_q == S_ERR2);
    assign bus.HRDATA    = (done && !wr_q) ? rval : '0;

`ifdef AHB_REGBANK_WSTRB_EN
    always_comb begin
        wval = regs_q[idx_q];
        for (int b = 0; b < NB; b++)
            if (bus.HWSTRB[b]) wval[b*8 +: 8] = bus.HWDATA[b*8 +: 8];
    end
    assign unused = ^{bus.HTRANS[0], bus.HBURST};
`else
    assign wval   = bus.HWDATA;
    assign unused = ^{bus.HTRANS[0], bus.HBURST, bus.HWSTRB};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dp_d    = dp_q & ~done;
        wr_d    = wr_q;
        idx_d   = idx_q;
        if (acc) begin
            wr_d    = bus.HWRITE;
            idx_d   = idx_a[RW-1:0];
            dp_d    = !err;
            cnt_d   = 3'(WAIT_STATES);
            state_d = err ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_IDLE);
        end else begin
            cnt_d   = cnt_q - {2'b00, cnt_q != 3'd0};
            state_d = (state_q == S_ERR1) ? S_ERR2 :
                      ((state_q == S_WAIT) && (cnt_q != 3'd0)) ? S_WAIT : S_IDLE;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++)
            regs_d[i] = (done && wr_q && (idx_q == RW'(i))) ? wval : regs_q[i];
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dp_q    <= 1'b0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dp_q    <= dp_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end
endmodule

// File: tb/tb_ahb_sub_regbank.sv
// tb_ahb_sub_regbank: directed scoreboard bench for ahb_sub_regbank with a zero-wait and a three-wait instance.
module tb_ahb_sub_regbank;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam int W  = NR * DW;
`ifdef AHB_REGBANK_WSTRB_EN
    localparam logic [3:0] SMASK = 4'h0;
`else
    localparam logic [3:0] SMASK = 4'hF;
`endif
    localparam logic [31:0] RV3 = 32'hCAFE_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          hsel [2];
    logic [AW-1:0] haddr [2];
    logic [1:0]    htrans [2];
    logic          hwrite [2];
    logic [2:0]    hsize [2];
    logic [DW-1:0] hwdata [2];
    logic [3:0]    hwstrb [2];
    logic          hready_o [2];
    logic          hresp_o [2];
    logic [DW-1:0] hrdata_o [2];
    logic [W-1:0]  status0, status3, regq0, regq3;
    logic [31:0]   mdl0 [NR];
    logic [31:0]   mdl3 [NR];
    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        rsp;
        int          lows;
    } exp_t;
    exp_t sb[$];

    ahb_sub_regbank_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    ahb_sub_regbank_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    assign bus0.HSEL = hsel[0];     assign bus3.HSEL = hsel[1];
    assign bus0.HADDR = haddr[0];   assign bus3.HADDR = haddr[1];
    assign bus0.HTRANS = htrans[0]; assign bus3.HTRANS = htrans[1];
    assign bus0.HWRITE = hwrite[0]; assign bus3.HWRITE = hwrite[1];
    assign bus0.HSIZE = hsize[0];   assign bus3.HSIZE = hsize[1];
    assign bus0.HBURST = 3'b001;    assign bus3.HBURST = 3'b001;
    assign bus0.HWDATA = hwdata[0]; assign bus3.HWDATA = hwdata[1];
    assign bus0.HWSTRB = hwstrb[0]; assign bus3.HWSTRB = hwstrb[1];
    assign bus0.HREADY = bus0.HREADYOUT;
    assign bus3.HREADY = bus3.HREADYOUT;
    assign hready_o[0] = bus0.HREADYOUT; assign hready_o[1] = bus3.HREADYOUT;
    assign hresp_o[0] = bus0.HRESP;      assign hresp_o[1] = bus3.HRESP;
    assign hrdata_o[0] = bus0.HRDATA;    assign hrdata_o[1] = bus3.HRDATA;

    ahb_sub_regbank #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .WAIT_STATES(0),
                      .RO_MASK(16'h0004), .RESET_VAL(32'h0)) dut0 (
        .HCLK(clk), .HRESET(rst), .bus(bus0), .status_i(status0), .reg_q(regq0));

    ahb_sub_regbank #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .WAIT_STATES(3),
                      .RO_MASK(16'h0004), .RESET_VAL(RV3)) dut3 (
        .HCLK(clk), .HRESET(rst), .bus(bus3), .status_i(status3), .reg_q(regq3));

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? w[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [W-1:0] pack(input int d);
        logic [W-1:0] r;
        for (int i = 0; i < NR; i++)
            r[i*DW +: DW] = (i == 2) ? (d == 0 ? status0[i*DW +: DW] : status3[i*DW +: DW])
                                     : (d == 0 ? mdl0[i] : mdl3[i]);
        return r;
    endfunction

    task automatic xfer(input int d, input bit w, input logic [AW-1:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic rsp, output int lows, output logic rsp_low);
        hsel[d] = 1'b1; htrans[d] = 2'b10; hwrite[d] = w; haddr[d] = a; hsize[d] = sz;
        @(posedge clk); #1;
        hsel[d] = 1'b0; htrans[d] = 2'b00; hwdata[d] = wd; hwstrb[d] = st;
        lows = 0; rsp_low = 1'b0; rd = 'x; rsp = 1'bx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hready_o[d]) begin
                rd = hrdata_o[d];
                rsp = hresp_o[d];
                break;
            end
            lows++;
            rsp_low |= hresp_o[d];
        end
        @(posedge clk); #1;
    endtask

    task automatic issue(input int d, input string tag, input bit w, input logic [AW-1:0] a,
                         input logic [2:0] sz, input logic [31:0] wd, input logic [3:0] st,
                         input logic [31:0] e_rd, input logic e_rsp, input int e_lows);
        logic [31:0] rd;
        logic rsp, rsp_low;
        int lows;
        exp_t e;
        sb.push_back('{tag, e_rd, e_rsp, e_lows});
        xfer(d, w, a, sz, wd, st, rd, rsp, lows, rsp_low);
        e = sb.pop_front();
        chk({e.tag, "_lows"}, W'(lows), W'(e.lows));
        chk({e.tag, "_resp"}, W'(rsp), W'(e.rsp));
        if (e.rsp) chk({e.tag, "_err1_resp"}, W'(rsp_low), W'(1'b1));
        if (!w && !e.rsp) chk({e.tag, "_rdata"}, W'(rd), W'(e.rd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            hsel[i] = 1'b0; haddr[i] = '0; htrans[i] = 2'b00; hwrite[i] = 1'b0;
            hsize[i] = 3'd2; hwdata[i] = '0; hwstrb[i] = 4'hF;
        end
        status0 = {NR{32'hF0F0_F0F0}};
        status0[2*DW +: DW] = 32'h1234_5678;
        status3 = {NR{32'h0F0F_0F0F}};
        status3[2*DW +: DW] = 32'h0BAD_F00D;
        for (int i = 0; i < NR; i++) begin
            mdl0[i] = 32'h0;
            mdl3[i] = RV3;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hready", W'(hready_o[0]), W'(1'b1));
        chk("rst_hresp", W'(hresp_o[0]), W'(1'b0));
        chk("rst_hrdata", W'(hrdata_o[0]), W'(32'h0));
        chk("rst_regq0", regq0, pack(0));
        chk("rst_regq3", regq3, pack(1));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        issue(0, "wr_deadbeef", 1'b1, 12'h004, 3'd2, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0);
        mdl0[1] = 32'hDEAD_BEEF;
        chk("regq_after_wr", regq0, pack(0));
        issue(0, "rd_deadbeef", 1'b0, 12'h004, 3'd2, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 0);
        @(negedge clk);
        chk("idle_hrdata_zero", W'(hrdata_o[0]), W'(32'h0));
        @(posedge clk); #1;

        issue(0, "wr_oor", 1'b1, 12'h040, 3'd2, 32'h1111_1111, 4'hF, 32'h0, 1'b1, 1);
        chk("regq_after_oor", regq0, pack(0));

        issue(0, "wr_ro", 1'b1, 12'h008, 3'd2, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1);
        issue(0, "rd_ro", 1'b0, 12'h008, 3'd2, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 0);

        issue(0, "wr_strb", 1'b1, 12'h00C, 3'd2, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 0);
        mdl0[3] = merge(mdl0[3], 32'hAABB_CCDD, 4'b0101 | SMASK);
        issue(0, "rd_strb", 1'b0, 12'h00C, 3'd2, 32'h0, 4'hF, mdl0[3], 1'b0, 0);

        issue(0, "rd_bigsize", 1'b0, 12'h010, 3'd3, 32'h0, 4'hF, 32'h0, 1'b1, 1);
        issue(0, "wr_misalign", 1'b1, 12'h006, 3'd2, 32'h2222_2222, 4'hF, 32'h0, 1'b1, 1);
        issue(0, "wr_half_misalign", 1'b1, 12'h005, 3'd1, 32'h3333_3333, 4'hF, 32'h0, 1'b1, 1);
        chk("regq_after_errs", regq0, pack(0));
        issue(0, "wr_half", 1'b1, 12'h006, 3'd1, 32'h0000_5A5A, 4'b1100, 32'h0, 1'b0, 0);
        mdl0[1] = merge(mdl0[1], 32'h0000_5A5A, 4'b1100 | SMASK);
        chk("regq_after_half", regq0, pack(0));

        hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; haddr[0] = 12'h014; hsize[0] = 3'd2;
        @(posedge clk); #1;
        hwdata[0] = 32'h5555_AAAA; hwstrb[0] = 4'hF; hwrite[0] = 1'b0;
        @(negedge clk);
        chk("b2b_wr_ready", W'(hready_o[0]), W'(1'b1));
        @(posedge clk); #1;
        hsel[0] = 1'b0; htrans[0] = 2'b00;
        mdl0[5] = 32'h5555_AAAA;
        @(negedge clk);
        chk("b2b_rd_ready", W'(hready_o[0]), W'(1'b1));
        chk("b2b_rd_data", W'(hrdata_o[0]), W'(mdl0[5]));
        @(posedge clk); #1;

        hsel[0] = 1'b1; hwrite[0] = 1'b1; haddr[0] = 12'h018; hwdata[0] = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            htrans[0] = (i < 2) ? 2'b00 : 2'b01;
            @(negedge clk);
            chk("idle_busy_ready", W'(hready_o[0]), W'(1'b1));
            chk("idle_busy_resp", W'(hresp_o[0]), W'(1'b0));
            @(posedge clk); #1;
        end
        hsel[0] = 1'b0; htrans[0] = 2'b10;
        repeat (2) @(posedge clk);
        #1 htrans[0] = 2'b00;
        chk("regq_after_idle", regq0, pack(0));

        issue(1, "ws3_rd0", 1'b0, 12'h000, 3'd2, 32'h0, 4'hF, RV3, 1'b0, 3);
        issue(1, "ws3_wr1", 1'b1, 12'h004, 3'd2, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 3);
        mdl3[1] = 32'h1122_3344;
        issue(1, "ws3_rd1", 1'b0, 12'h004, 3'd2, 32'h0, 4'hF, 32'h1122_3344, 1'b0, 3);
        issue(1, "ws3_oor", 1'b1, 12'h040, 3'd2, 32'h0, 4'hF, 32'h0, 1'b1, 1);
        issue(1, "ws3_rd_ro", 1'b0, 12'h008, 3'd2, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0, 3);
        chk("regq3_mid", regq3, pack(1));

        hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; haddr[1] = 12'h00C; hsize[1] = 3'd2;
        @(posedge clk); #1;
        hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'h9999_9999; hwstrb[1] = 4'hF;
        @(negedge clk);
        chk("rstw_in_wait", W'(hready_o[1]), W'(1'b0));
        #1 rst = 1'b1;
        for (int i = 0; i < NR; i++) begin
            mdl0[i] = 32'h0;
            mdl3[i] = RV3;
        end
        #1;
        chk("rstw_hready", W'(hready_o[1]), W'(1'b1));
        chk("rstw_hresp", W'(hresp_o[1]), W'(1'b0));
        chk("rstw_hrdata", W'(hrdata_o[1]), W'(32'h0));
        chk("rstw_regq3", regq3, pack(1));
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready", W'(hready_o[1]), W'(1'b1));
        chk("post_rst_regq3", regq3, pack(1));
        chk("post_rst_regq0", regq0, pack(0));
        @(posedge clk); #1;
        issue(1, "post_rst_rd", 1'b0, 12'h00C, 3'd2, 32'h0, 4'hF, RV3, 1'b0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_sub_regbank.md
AHB_SUB_REGBANK -- requirements
Module: ahb_sub_regbank

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, HADDR width.
REQ-002 SHALL have parameter DATA_W, default 32, bus/register width; legal values 32 or 64.
REQ-003 SHALL have parameter NUM_REGS, default 16, register count; legal range 1..256.
REQ-004 SHALL have parameter WAIT_STATES, default 0, data-phase wait cycles; legal range 0..7.
REQ-005 SHALL have parameter RO_MASK, NUM_REGS bits, default 0; bit i=1 makes register i read-only, sourced from status_i.
REQ-006 SHALL have parameter RESET_VAL, DATA_W bits, default 0, reset value of every RW register.
REQ-007 SHALL have port HCLK, input, 1 bit, the single clock; all logic is rising-edge.
REQ-008 SHALL have port HRESET, input, 1 bit, asynchronous, active-high reset.
REQ-009 SHALL have inputs HSEL (1), HADDR (ADDR_W), HTRANS (2), HWRITE (1), HSIZE (3), HBURST (3), HWDATA (DATA_W), HWSTRB (DATA_W/8) and HREADY (1), all AHB-Lite manager/interconnect signals.
REQ-010 SHALL have outputs HRDATA (DATA_W), HREADYOUT (1) and HRESP (1), all AHB subordinate responses.
REQ-011 SHALL have input status_i (NUM_REGS*DATA_W), giving read values of RO registers.
REQ-012 SHALL have output reg_q (NUM_REGS*DATA_W), the current contents of all registers.

Function
REQ-013 SHALL accept an address phase only when HSEL=1, HTRANS[1]=1 and HREADY=1; SHALL capture the address, HWRITE and HSIZE at that edge.
REQ-014 SHALL use register index HADDR[ADDR_W-1:log2(DATA_W/8)].
REQ-015 SHALL flag an error if any of these holds: index >= NUM_REGS; write to an RO register; HSIZE > log2(DATA_W/8); address misaligned for HSIZE.
REQ-016 SHALL use FSM states IDLE, WAIT and ERR1, ERR2.
REQ-017 In IDLE, SHALL drive HREADYOUT=1 and HRESP=0.
REQ-018 On a valid accepted transfer, SHALL go IDLE->WAIT when WAIT_STATES>0; otherwise SHALL complete in the following cycle with the FSM remaining in IDLE.
REQ-019 In WAIT, SHALL hold HREADYOUT=0 for exactly WAIT_STATES cycles, then give a one-cycle completion with HREADYOUT=1 and HRESP=0, and return to IDLE.
REQ-020 On an errored accepted transfer, SHALL enter ERR1 immediately, with no wait states, and drive HRESP=1, HREADYOUT=0.
REQ-021 From ERR1, SHALL go to ERR2 and drive HRESP=1, HREADYOUT=1, then return to IDLE.
REQ-022 On an errored transfer, SHALL update no register.
REQ-023 On write completion, SHALL update register bytes selected by HWSTRB from HWDATA; the register is visible on reg_q in the next cycle.
REQ-024 On read completion, SHALL present the RW register value or status_i slice on HRDATA; at all other times SHALL drive HRDATA=0.
REQ-025 SHALL return the newly written value on a read immediately following a write to the same register.
REQ-026 SHALL accept a new address phase in the completion cycle (pipelined, back-to-back, no bubble); SHALL ignore HBURST and treat bursts as individual transfers.
REQ-027 SHALL complete IDLE and BUSY transfers, and unselected cycles, with zero-wait OKAY and no side effects.

Reset
REQ-028 While HRESET=1, SHALL set all RW registers to RESET_VAL, the FSM to IDLE, HREADYOUT=1, HRESP=0 and HRDATA=0.
REQ-029 On a reset asserted mid-transfer, SHALL abandon the transfer with no register write and accept no pending data phase after release.

Configuration
REQ-030 Macro AHB_REGBANK_WSTRB_EN defined: SHALL honour HWSTRB per byte.
REQ-031 Macro AHB_REGBANK_WSTRB_EN undefined: SHALL ignore HWSTRB, write whole registers, and leave the HWSTRB port present but unused.

Verification
REQ-032 SHALL cover: WAIT_STATES=0, write 0xDEADBEEF to addr 0x004, read it back -> HRDATA=0xDEADBEEF on the next completion, HREADYOUT never low.
REQ-033 SHALL cover: WAIT_STATES=3, single read -> exactly 3 cycles of HREADYOUT=0, then completion with HRESP=0.
REQ-034 SHALL cover: write to addr 0x040 with NUM_REGS=16 -> ERR1 then ERR2 (HRESP=1 for 2 cycles, HREADYOUT 0 then 1), reg_q unchanged.
REQ-035 SHALL cover: RO_MASK bit 2 set, status_i slice=0x12345678, write then read addr 0x008 -> write errors, read returns 0x12345678.
REQ-036 SHALL cover, with WSTRB_EN: register=0x00000000, write 0xAABBCCDD with HWSTRB=4'b0101 -> register 0x00BB00DD.
REQ-037 SHALL cover: HRESET asserted during a WAIT-state write -> outputs at reset values, register=RESET_VAL, no write after release.
